// File: rtl/mac_tx_frame.sv
// mac_tx_frame
//
// Ethernet transmit framer placed after the port/ARP/IGMP transmit manager.
// On a request it grants with a one-cycle ApplyReply and latches one byte
// source (IGMPv3 > ARP > UDP). It then emits one contiguous GMII burst:
// preamble, SFD, payload, zero pad up to MIN_FRAME, and a CRC-32 FCS sent
// LSB first. After IFG_BYTES idle cycles it pulses MacTxOver.
//
// Parameters
//   MIN_FRAME  minimum payload+pad bytes ahead of the FCS (1..1514)
//   MAX_FRAME  payload byte limit; reaching it without Last truncates
//   IFG_BYTES  idle cycles after the FCS (1..255)
//
// Ports
//   clk, rst                  byte clock, asynchronous active-high reset
//   ApplyMacTx                transmit request level (sampled in IDLE only)
//   StartIGMPv3Send,
//   ARPDaEnToSend,
//   UDPDaEnToSend             source-select levels
//   ApplyReply                one-cycle grant pulse
//   MacTxOver                 one-cycle pulse at the end of the gap
//   IgmpTxRd/ArpTxRd/UdpTxRd  show-ahead byte-read strobes
//   *TxData, *TxLast          source byte and last-byte flag, valid with Rd
//   TxEn, TxD                 registered GMII transmit enable and data
//   TruncErr                  one-cycle pulse when a frame is cut at MAX_FRAME
//
// The state name describes what TxEn/TxD show in that cycle; the
// combinational block decides what the output register loads for the
// following cycle.

module mac_tx_frame #(
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ApplyMacTx,
  input  logic       StartIGMPv3Send,
  input  logic       ARPDaEnToSend,
  input  logic       UDPDaEnToSend,
  output logic       ApplyReply,
  output logic       MacTxOver,
  output logic       IgmpTxRd,
  output logic       ArpTxRd,
  output logic       UdpTxRd,
  input  logic [7:0] IgmpTxData,
  input  logic [7:0] ArpTxData,
  input  logic [7:0] UdpTxData,
  input  logic       IgmpTxLast,
  input  logic       ArpTxLast,
  input  logic       UdpTxLast,
  output logic       TxEn,
  output logic [7:0] TxD,
  output logic       TruncErr
);

  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [7:0]  PRE_LAST = 8'd6;
  localparam logic [7:0]  BYTE_PRE = 8'h55;
  localparam logic [7:0]  BYTE_SFD = 8'hD5;

  typedef enum logic [2:0] {
    IDLE, GRANT, PRE, SFD, DATA, PAD, FCS, IFG
  } state_t;

  typedef enum logic [1:0] {
    SRC_IGMP, SRC_ARP, SRC_UDP
  } src_t;

  // Reflected CRC-32 (poly 0x04C11DB7, reflected constant 0xEDB88320),
  // one byte per call, LSB of the byte first.
  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  state_t      state, stateNxt;
  src_t        src, srcNxt;
  logic [7:0]  phaseCnt, phaseNxt;   // PRE index, FCS byte index, IFG count
  logic [10:0] byteCnt, byteNxt;     // payload+pad bytes emitted
  logic        moreData, moreNxt;    // source still has bytes to read
  logic [31:0] crc, crcNxt;
  logic [31:0] fcsWord;
  logic        rdStrobe;
  logic        selAny;
  logic [7:0]  curData;
  logic        curLast;
  logic        txEn_p1, txEnNxt;
  logic [7:0]  txDat_p1, txDatNxt;
  logic        truncErr_p1, truncNxt;

  assign selAny  = StartIGMPv3Send | ARPDaEnToSend | UDPDaEnToSend;
  assign fcsWord = ~crc;

  always_comb begin
    curData = UdpTxData;
    curLast = UdpTxLast;
    case (src)
      SRC_IGMP: begin curData = IgmpTxData; curLast = IgmpTxLast; end
      SRC_ARP:  begin curData = ArpTxData;  curLast = ArpTxLast;  end
      default:  begin curData = UdpTxData;  curLast = UdpTxLast;  end
    endcase
  end

  // Next-state and datapath decode
  always_comb begin
    stateNxt = state;
    srcNxt   = src;
    phaseNxt = phaseCnt;
    byteNxt  = byteCnt;
    moreNxt  = moreData;
    crcNxt   = crc;
    txEnNxt  = 1'b0;
    txDatNxt = 8'h00;
    truncNxt = 1'b0;
    rdStrobe = 1'b0;

    case (state)
      IDLE: begin
        if (ApplyMacTx && selAny) begin
          stateNxt = GRANT;
          if (StartIGMPv3Send)    srcNxt = SRC_IGMP;
          else if (ARPDaEnToSend) srcNxt = SRC_ARP;
          else                    srcNxt = SRC_UDP;
        end
      end

      GRANT: begin
        stateNxt = PRE;
        phaseNxt = 8'd0;
        byteNxt  = 11'd0;
        crcNxt   = 32'hFFFFFFFF;
        moreNxt  = 1'b1;
        txEnNxt  = 1'b1;
        txDatNxt = BYTE_PRE;
      end

      PRE: begin
        txEnNxt = 1'b1;
        if (phaseCnt == PRE_LAST) begin
          txDatNxt = BYTE_SFD;
          stateNxt = SFD;
        end else begin
          txDatNxt = BYTE_PRE;
          phaseNxt = phaseCnt + 8'd1;
        end
      end

      // SFD on the wire is also the first read cycle; thereafter each
      // DATA cycle reads the byte that goes out next. Once the source is
      // exhausted the same branch chooses between pad and FCS.
      SFD, DATA, PAD: begin
        txEnNxt = 1'b1;
        if (moreData) begin
          rdStrobe = 1'b1;
          txDatNxt = curData;
          crcNxt   = crcByte(crc, curData);
          byteNxt  = byteCnt + 11'd1;
          stateNxt = DATA;
          if (curLast || (byteCnt == MAX_CNT)) begin
            moreNxt  = 1'b0;
            truncNxt = ~curLast;
          end
        end else if (byteCnt < MIN_CNT) begin
          txDatNxt = 8'h00;
          crcNxt   = crcByte(crc, 8'h00);
          byteNxt  = byteCnt + 11'd1;
          stateNxt = PAD;
        end else begin
          txDatNxt = fcsWord[7:0];
          phaseNxt = 8'd0;
          stateNxt = FCS;
        end
      end

      FCS: begin
        if (phaseCnt[1:0] == 2'd3) begin
          stateNxt = IFG;
          phaseNxt = 8'd0;
        end else begin
          txEnNxt  = 1'b1;
          phaseNxt = phaseCnt + 8'd1;
          case (phaseCnt[1:0])
            2'd0:    txDatNxt = fcsWord[15:8];
            2'd1:    txDatNxt = fcsWord[23:16];
            default: txDatNxt = fcsWord[31:24];
          endcase
        end
      end

      IFG: begin
        if (phaseCnt == IFG_LAST) stateNxt = IDLE;
        else                      phaseNxt = phaseCnt + 8'd1;
      end

      default: stateNxt = IDLE;
    endcase
  end

  // Stage p1: state, counters, CRC and the registered GMII outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      src         <= SRC_UDP;
      phaseCnt    <= 8'd0;
      byteCnt     <= 11'd0;
      moreData    <= 1'b0;
      crc         <= 32'hFFFFFFFF;
      txEn_p1     <= 1'b0;
      txDat_p1    <= 8'h00;
      truncErr_p1 <= 1'b0;
    end else begin
      state       <= stateNxt;
      src         <= srcNxt;
      phaseCnt    <= phaseNxt;
      byteCnt     <= byteNxt;
      moreData    <= moreNxt;
      crc         <= crcNxt;
      txEn_p1     <= txEnNxt;
      txDat_p1    <= txDatNxt;
      truncErr_p1 <= truncNxt;
    end
  end

  assign ApplyReply = (state == GRANT);
  assign MacTxOver  = (state == IFG) && (phaseCnt == IFG_LAST);
  assign IgmpTxRd   = rdStrobe && (src == SRC_IGMP);
  assign ArpTxRd    = rdStrobe && (src == SRC_ARP);
  assign UdpTxRd    = rdStrobe && (src == SRC_UDP);
  assign TxEn       = txEn_p1;
  assign TxD        = txDat_p1;
  assign TruncErr   = truncErr_p1;

endmodule

// File: tb/tb_mac_tx_frame.sv
// Testbench for mac_tx_frame. dutA runs with MIN_FRAME=1, MAX_FRAME=100;
// dutB runs with the default parameters for the padding case. Both share
// the source model; only the DUT whose ApplyMacTx is raised will frame.

module tb_mac_tx_frame;

  localparam int IFG = 12;

  logic clk = 1'b0;
  logic rst;
  logic apA, apB;
  logic selIgmp, selArp, selUdp;
  logic [7:0] igmpD, arpD, udpD;
  logic lastSig;

  logic replyA, overA, irdA, ardA, urdA, txEnA, truncA;
  logic [7:0] txDA;
  logic replyB, overB, irdB, ardB, urdB, txEnB, truncB;
  logic [7:0] txDB;

  always #4 clk = ~clk;

  mac_tx_frame #(.MIN_FRAME(1), .MAX_FRAME(100), .IFG_BYTES(IFG)) dutA (
    .clk(clk), .rst(rst), .ApplyMacTx(apA),
    .StartIGMPv3Send(selIgmp), .ARPDaEnToSend(selArp), .UDPDaEnToSend(selUdp),
    .ApplyReply(replyA), .MacTxOver(overA),
    .IgmpTxRd(irdA), .ArpTxRd(ardA), .UdpTxRd(urdA),
    .IgmpTxData(igmpD), .ArpTxData(arpD), .UdpTxData(udpD),
    .IgmpTxLast(lastSig), .ArpTxLast(lastSig), .UdpTxLast(lastSig),
    .TxEn(txEnA), .TxD(txDA), .TruncErr(truncA)
  );

  mac_tx_frame dutB (
    .clk(clk), .rst(rst), .ApplyMacTx(apB),
    .StartIGMPv3Send(selIgmp), .ARPDaEnToSend(selArp), .UDPDaEnToSend(selUdp),
    .ApplyReply(replyB), .MacTxOver(overB),
    .IgmpTxRd(irdB), .ArpTxRd(ardB), .UdpTxRd(urdB),
    .IgmpTxData(igmpD), .ArpTxData(arpD), .UdpTxData(udpD),
    .IgmpTxLast(lastSig), .ArpTxLast(lastSig), .UdpTxLast(lastSig),
    .TxEn(txEnB), .TxD(txDB), .TruncErr(truncB)
  );

  // Observed DUT selection
  bit useB = 1'b0;
  logic obsReply, obsOver, obsIrd, obsArd, obsUrd, obsTxEn, obsTrunc;
  logic [7:0] obsTxD;
  assign obsReply = useB ? replyB : replyA;
  assign obsOver  = useB ? overB  : overA;
  assign obsIrd   = useB ? irdB   : irdA;
  assign obsArd   = useB ? ardB   : ardA;
  assign obsUrd   = useB ? urdB   : urdA;
  assign obsTxEn  = useB ? txEnB  : txEnA;
  assign obsTxD   = useB ? txDB   : txDA;
  assign obsTrunc = useB ? truncB : truncA;

  // Show-ahead source model: each source XORs its own key so a wrong
  // source mux shows up as wrong bytes.
  logic [7:0] mem [256];
  logic [7:0] idx = 8'd0;
  int  srcLen = 1;
  bit  noLast = 1'b0;
  assign udpD    = mem[idx];
  assign arpD    = mem[idx] ^ 8'h5A;
  assign igmpD   = mem[idx] ^ 8'hC3;
  assign lastSig = !noLast && (int'(idx) == srcLen - 1);

  always @(posedge clk) begin
    if (replyA || replyB) idx <= 8'd0;
    else if (irdA | ardA | urdA | irdB | ardB | urdB) idx <= idx + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  // Capture results
  logic [7:0] txQ[$];
  int gCyc, firstEn, lastEn, overCyc, enCnt, rdI, rdA, rdU, truncCnt, replyCnt, overCnt;
  bit timedOut;

  function automatic logic [31:0] fcsOf(input logic [7:0] d[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic buildExp(input logic [7:0] pl[$], input int minLen, output logic [7:0] fr[$]);
    logic [7:0] body[$];
    logic [31:0] f;
    body = pl;
    while (body.size() < minLen) body.push_back(8'h00);
    f = fcsOf(body);
    fr.delete();
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (body[i]) fr.push_back(body[i]);
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
  endtask

  // Records one frame from grant to MacTxOver; drops the request on grant
  // and optionally drops all selects dropSelAt cycles after grant.
  task automatic capture(input int budget, input int dropSelAt);
    bit done, seenG;
    txQ.delete();
    gCyc = -1; firstEn = -1; lastEn = -1; overCyc = -1;
    enCnt = 0; rdI = 0; rdA = 0; rdU = 0; truncCnt = 0; replyCnt = 0; overCnt = 0;
    done = 1'b0; seenG = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (obsReply) begin
        replyCnt++;
        if (!seenG) begin seenG = 1'b1; gCyc = cyc; apA = 1'b0; apB = 1'b0; end
      end
      if (seenG && dropSelAt > 0 && cyc == gCyc + dropSelAt) begin
        selIgmp = 1'b0; selArp = 1'b0; selUdp = 1'b0;
      end
      if (obsTxEn) begin
        txQ.push_back(obsTxD);
        if (firstEn < 0) firstEn = cyc;
        lastEn = cyc;
        enCnt++;
      end
      if (obsIrd) rdI++;
      if (obsArd) rdA++;
      if (obsUrd) rdU++;
      if (obsTrunc) truncCnt++;
      if (obsOver) begin overCnt++; overCyc = cyc; done = 1'b1; end
    end
    timedOut = !done;
  endtask

  task automatic test_reset;
    rst = 1'b1; apA = 1'b0; apB = 1'b0;
    selIgmp = 1'b0; selArp = 1'b0; selUdp = 1'b0;
    repeat (3) @(negedge clk);
    nTests++; if ({txEnA, txDA} !== 9'h000) begin nFail++; $display("FAIL reset_tx got %b/%02h want 0/00", txEnA, txDA); end
    nTests++; if ({replyA, overA, truncA} !== 3'b000) begin nFail++; $display("FAIL reset_pulses got %b want 000", {replyA, overA, truncA}); end
    nTests++; if ({irdA, ardA, urdA} !== 3'b000) begin nFail++; $display("FAIL reset_rd got %b want 000", {irdA, ardA, urdA}); end
    nTests++; if ({txEnB, txDB, replyB, overB} !== 11'h000) begin nFail++; $display("FAIL reset_dutB got %h want 000", {txEnB, txDB, replyB, overB}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nTests++; if ({txEnA, replyA, overA} !== 3'b000) begin nFail++; $display("FAIL idle_after_reset got %b want 000", {txEnA, replyA, overA}); end
  endtask

  task automatic test_known_crc;
    logic [7:0] exp[$];
    exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
            8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    srcLen = 9; noLast = 1'b0; useB = 1'b0;
    selUdp = 1'b1; apA = 1'b1;
    capture(200, 0);
    nTests++; if (timedOut !== 1'b0) begin nFail++; $display("FAIL crc9_timeout got %b want 0", timedOut); end
    nTests++; if (replyCnt !== 1) begin nFail++; $display("FAIL crc9_reply_count got %0d want 1", replyCnt); end
    nTests++; if (firstEn !== gCyc + 1) begin nFail++; $display("FAIL crc9_first_txen got %0d want %0d", firstEn, gCyc + 1); end
    nTests++; if (enCnt !== 21) begin nFail++; $display("FAIL crc9_txen_cycles got %0d want 21", enCnt); end
    nTests++; if (lastEn - firstEn + 1 !== enCnt) begin nFail++; $display("FAIL crc9_contiguous span %0d count %0d", lastEn - firstEn + 1, enCnt); end
    nTests++; if (overCyc !== lastEn + IFG) begin nFail++; $display("FAIL crc9_over_cycle got %0d want %0d", overCyc, lastEn + IFG); end
    nTests++; if ({rdI, rdA, rdU} !== {32'd0, 32'd0, 32'd9}) begin nFail++; $display("FAIL crc9_reads got %0d/%0d/%0d want 0/0/9", rdI, rdA, rdU); end
    nTests++; if (txQ.size() !== exp.size()) begin nFail++; $display("FAIL crc9_len got %0d want %0d", txQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < txQ.size(); i++) begin
      nTests++; if (txQ[i] !== exp[i]) begin nFail++; $display("FAIL crc9_byte[%0d] got %02h want %02h", i, txQ[i], exp[i]); end
    end
    @(negedge clk);
    nTests++; if (overA !== 1'b0) begin nFail++; $display("FAIL crc9_over_width got %b want 0", overA); end
    selUdp = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] pl[$], exp[$];
    int prevOver;
    for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
    srcLen = 5; useB = 1'b0;
    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(mem[i] ^ 8'h5A);
    buildExp(pl, 1, exp);
    selArp = 1'b1; apA = 1'b1;
    capture(200, 0);
    nTests++; if (timedOut !== 1'b0) begin nFail++; $display("FAIL b2b_first_timeout got %b want 0", timedOut); end
    prevOver = overCyc;
    apA = 1'b1;
    @(negedge clk);
    nTests++; if ({replyA, overA} !== 2'b00) begin nFail++; $display("FAIL b2b_idle_cycle got %b want 00", {replyA, overA}); end
    capture(200, 0);
    nTests++; if (gCyc !== prevOver + 2) begin nFail++; $display("FAIL b2b_grant_cycle got %0d want %0d", gCyc, prevOver + 2); end
    nTests++; if (rdA !== 5) begin nFail++; $display("FAIL b2b_arp_reads got %0d want 5", rdA); end
    nTests++; if (txQ.size() !== exp.size()) begin nFail++; $display("FAIL b2b_len got %0d want %0d", txQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < txQ.size(); i++) begin
      nTests++; if (txQ[i] !== exp[i]) begin nFail++; $display("FAIL b2b_byte[%0d] got %02h want %02h", i, txQ[i], exp[i]); end
    end
    selArp = 1'b0;
  endtask

  task automatic test_pad;
    logic [7:0] pl[$], exp[$];
    for (int i = 0; i < 42; i++) mem[i] = 8'(i * 7 + 3);
    srcLen = 42; noLast = 1'b0; useB = 1'b1;
    pl.delete();
    for (int i = 0; i < 42; i++) pl.push_back(mem[i] ^ 8'h5A);
    buildExp(pl, 60, exp);
    selArp = 1'b1; apB = 1'b1;
    capture(400, 0);
    nTests++; if (timedOut !== 1'b0) begin nFail++; $display("FAIL pad_timeout got %b want 0", timedOut); end
    nTests++; if ({rdI, rdA, rdU} !== {32'd0, 32'd42, 32'd0}) begin nFail++; $display("FAIL pad_reads got %0d/%0d/%0d want 0/42/0", rdI, rdA, rdU); end
    nTests++; if (enCnt !== 72) begin nFail++; $display("FAIL pad_txen_cycles got %0d want 72", enCnt); end
    nTests++; if (lastEn - firstEn + 1 !== enCnt) begin nFail++; $display("FAIL pad_contiguous span %0d count %0d", lastEn - firstEn + 1, enCnt); end
    nTests++; if (truncCnt !== 0) begin nFail++; $display("FAIL pad_trunc got %0d want 0", truncCnt); end
    nTests++; if (overCyc !== lastEn + IFG) begin nFail++; $display("FAIL pad_over_cycle got %0d want %0d", overCyc, lastEn + IFG); end
    nTests++; if (txQ.size() !== exp.size()) begin nFail++; $display("FAIL pad_len got %0d want %0d", txQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < txQ.size(); i++) begin
      nTests++; if (txQ[i] !== exp[i]) begin nFail++; $display("FAIL pad_byte[%0d] got %02h want %02h", i, txQ[i], exp[i]); end
    end
    selArp = 1'b0; useB = 1'b0;
  endtask

  task automatic test_priority;
    logic [7:0] pl[$], exp[$];
    for (int i = 0; i < 20; i++) mem[i] = 8'h10 + 8'(i * 3);
    srcLen = 20; useB = 1'b0;
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(mem[i] ^ 8'hC3);
    buildExp(pl, 1, exp);
    selIgmp = 1'b1; selArp = 1'b1; selUdp = 1'b1; apA = 1'b1;
    capture(300, 12);
    nTests++; if (timedOut !== 1'b0) begin nFail++; $display("FAIL prio_timeout got %b want 0", timedOut); end
    nTests++; if ({rdI, rdA, rdU} !== {32'd20, 32'd0, 32'd0}) begin nFail++; $display("FAIL prio_reads got %0d/%0d/%0d want 20/0/0", rdI, rdA, rdU); end
    nTests++; if (txQ.size() !== exp.size()) begin nFail++; $display("FAIL prio_len got %0d want %0d", txQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < txQ.size(); i++) begin
      nTests++; if (txQ[i] !== exp[i]) begin nFail++; $display("FAIL prio_byte[%0d] got %02h want %02h", i, txQ[i], exp[i]); end
    end
  endtask

  task automatic test_truncate;
    logic [7:0] pl[$], exp[$];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 5 + 1);
    srcLen = 256; noLast = 1'b1; useB = 1'b0;
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(mem[i]);
    buildExp(pl, 1, exp);
    selUdp = 1'b1; apA = 1'b1;
    capture(400, 0);
    nTests++; if (timedOut !== 1'b0) begin nFail++; $display("FAIL trunc_timeout got %b want 0", timedOut); end
    nTests++; if (rdU !== 100) begin nFail++; $display("FAIL trunc_reads got %0d want 100", rdU); end
    nTests++; if (truncCnt !== 1) begin nFail++; $display("FAIL trunc_pulses got %0d want 1", truncCnt); end
    nTests++; if (overCyc !== lastEn + IFG) begin nFail++; $display("FAIL trunc_over_cycle got %0d want %0d", overCyc, lastEn + IFG); end
    nTests++; if (txQ.size() !== exp.size()) begin nFail++; $display("FAIL trunc_len got %0d want %0d", txQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < txQ.size(); i++) begin
      nTests++; if (txQ[i] !== exp[i]) begin nFail++; $display("FAIL trunc_byte[%0d] got %02h want %02h", i, txQ[i], exp[i]); end
    end
    noLast = 1'b0; selUdp = 1'b0;
  endtask

  task automatic test_no_select;
    int replies, enSeen;
    bit overSeen;
    for (int i = 0; i < 4; i++) mem[i] = 8'hE0 + 8'(i);
    srcLen = 4; useB = 1'b0;
    selIgmp = 1'b0; selArp = 1'b0; selUdp = 1'b0;
    apA = 1'b1;
    replies = 0; enSeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (replyA) replies++;
      if (txEnA) enSeen++;
    end
    nTests++; if (replies !== 0) begin nFail++; $display("FAIL nosel_reply got %0d want 0", replies); end
    nTests++; if (enSeen !== 0) begin nFail++; $display("FAIL nosel_txen got %0d want 0", enSeen); end
    selUdp = 1'b1;
    @(negedge clk);
    nTests++; if (replyA !== 1'b1) begin nFail++; $display("FAIL nosel_late_grant got %b want 1", replyA); end
    apA = 1'b0;
    overSeen = 1'b0;
    for (int k = 0; k < 100 && !overSeen; k++) begin
      @(negedge clk);
      if (overA) overSeen = 1'b1;
    end
    nTests++; if (overSeen !== 1'b1) begin nFail++; $display("FAIL nosel_frame_done got %b want 1", overSeen); end
    selUdp = 1'b0;
  endtask

  task automatic test_rst_mid;
    logic [7:0] pl[$], exp[$];
    bit granted;
    int overs, ens;
    for (int i = 0; i < 20; i++) mem[i] = 8'h40 + 8'(i);
    srcLen = 20; useB = 1'b0;
    selUdp = 1'b1; apA = 1'b1;
    granted = 1'b0;
    for (int k = 0; k < 10 && !granted; k++) begin
      @(negedge clk);
      if (replyA) granted = 1'b1;
    end
    apA = 1'b0;
    nTests++; if (granted !== 1'b1) begin nFail++; $display("FAIL rstmid_grant got %b want 1", granted); end
    repeat (12) @(negedge clk);
    nTests++; if (txEnA !== 1'b1) begin nFail++; $display("FAIL rstmid_txen_before got %b want 1", txEnA); end
    rst = 1'b1;
    #1;
    nTests++; if ({txEnA, urdA} !== 2'b00) begin nFail++; $display("FAIL rstmid_async_drop got %b want 00", {txEnA, urdA}); end
    @(negedge clk);
    rst = 1'b0;
    overs = 0; ens = 0;
    repeat (40) begin
      @(negedge clk);
      if (overA) overs++;
      if (txEnA) ens++;
    end
    nTests++; if (overs !== 0) begin nFail++; $display("FAIL rstmid_no_over got %0d want 0", overs); end
    nTests++; if (ens !== 0) begin nFail++; $display("FAIL rstmid_quiet got %0d want 0", ens); end
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(mem[i]);
    buildExp(pl, 1, exp);
    apA = 1'b1;
    capture(300, 0);
    nTests++; if (timedOut !== 1'b0) begin nFail++; $display("FAIL rstmid_next_timeout got %b want 0", timedOut); end
    nTests++; if (txQ.size() !== exp.size()) begin nFail++; $display("FAIL rstmid_next_len got %0d want %0d", txQ.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < txQ.size(); i++) begin
      nTests++; if (txQ[i] !== exp[i]) begin nFail++; $display("FAIL rstmid_next_byte[%0d] got %02h want %02h", i, txQ[i], exp[i]); end
    end
    selUdp = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_known_crc();
    test_back_to_back();
    test_pad();
    test_priority();
    test_truncate();
    test_no_select();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
